// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller in front of a word-addressed
// data memory. Converts byte-addressed byte/half/word requests into word
// accesses. Sub-word stores use read-modify-write. Loads are sign- or
// zero-extended. Misaligned and out-of-range requests are flagged.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-low reset
//   req_*               request channel from EX/MEM (valid/ready handshake)
//   resp_valid/rdata    one-cycle completion pulse with extended load data
//   misalign_err        misaligned or illegal-size request (with resp_valid)
//   range_err           word index beyond MEM_WORDS (with resp_valid)
//   stall               hold the upstream pipeline
//   mem_*               word-index interface to the data memory
module mem_access_unit #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned BIG_ENDIAN = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign_err,
  output logic        range_err,
  output logic        stall,
  output logic [31:0] mem_address,
  output logic        mem_readEn,
  output logic        mem_writeEn,
  output logic [31:0] mem_WriteData,
  input  logic [31:0] mem_ReadData
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, MRG, WR, RESP, ERR} state_t;

  state_t      state, state_nxt;

  // Captured request
  logic        write_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;     // sub-word stores only need the low halfword
  logic [31:0] rd_word_q;   // word read during RD, merged in MRG

  logic        accept;
  logic        mis_c, rng_c;
  logic        rd_en_nxt, wr_en_nxt, resp_valid_nxt, mis_nxt, rng_nxt;
  logic [31:0] addr_nxt, wdata_nxt, rdata_nxt;

  // Lane mapping: big-endian mirrors byte and halfword lanes within the word
  function automatic logic [1:0] byte_lane(input logic [1:0] a);
    return (BIG_ENDIAN != 0) ? ~a : a;
  endfunction

  function automatic logic half_lane(input logic a1);
    return (BIG_ENDIAN != 0) ? ~a1 : a1;
  endfunction

  // Select the addressed lane of a read word and extend it
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  size,
                                          input logic        uns,
                                          input logic [1:0]  a);
    logic [4:0]  sh;
    logic [31:0] w;
    logic [31:0] res;
    sh  = '0;
    w   = word;
    res = word;
    case (size)
      SZ_BYTE: begin
        sh  = 5'({byte_lane(a), 3'b000});
        w   = word >> sh;
        res = uns ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
      end
      SZ_HALF: begin
        sh  = 5'({half_lane(a[1]), 4'b0000});
        w   = word >> sh;
        res = uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      end
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/halfword lane of word with the store data
  function automatic logic [31:0] merge(input logic [31:0] word,
                                        input logic [15:0] data,
                                        input logic [1:0]  size,
                                        input logic [1:0]  a);
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] ins;
    if (size == SZ_BYTE) begin
      sh   = 5'({byte_lane(a), 3'b000});
      mask = 32'h0000_00FF << sh;
      ins  = {4{data[7:0]}};
    end else begin
      sh   = 5'({half_lane(a[1]), 4'b0000});
      mask = 32'h0000_FFFF << sh;
      ins  = {2{data}};
    end
    return (word & ~mask) | (ins & mask);
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && (state == IDLE);
  // Equivalent to busy || (req_valid while IDLE)
  assign stall     = (state != IDLE) || req_valid;

  // Request checks on the incoming (not yet captured) request
  assign mis_c = (req_size == SZ_ILL) ||
                 ((req_size == SZ_HALF) && req_addr[0]) ||
                 ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign rng_c = 32'(req_addr[31:2]) >= MEM_WORDS;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_nxt      = state;
    rd_en_nxt      = 1'b0;
    wr_en_nxt      = 1'b0;
    resp_valid_nxt = 1'b0;
    mis_nxt        = 1'b0;
    rng_nxt        = 1'b0;
    addr_nxt       = mem_address;
    wdata_nxt      = mem_WriteData;
    rdata_nxt      = resp_rdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (mis_c) begin
            state_nxt      = ERR;
            resp_valid_nxt = 1'b1;
            mis_nxt        = 1'b1;
            rdata_nxt      = '0;
          end else if (rng_c) begin
            state_nxt      = ERR;
            resp_valid_nxt = 1'b1;
            rng_nxt        = 1'b1;
            rdata_nxt      = '0;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_nxt = WR;
            wr_en_nxt = 1'b1;
            addr_nxt  = 32'(req_addr[31:2]);
            wdata_nxt = req_wdata;
          end else begin
            state_nxt = RD;
            rd_en_nxt = 1'b1;
            addr_nxt  = 32'(req_addr[31:2]);
          end
        end
      end
      RD: begin
        if (write_q) begin
          state_nxt = MRG;
        end else begin
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          rdata_nxt      = extract(mem_ReadData, size_q, unsigned_q, addr_q[1:0]);
        end
      end
      MRG: begin
        state_nxt = WR;
        wr_en_nxt = 1'b1;
        addr_nxt  = 32'(addr_q[31:2]);
        wdata_nxt = merge(rd_word_q, wdata_q, size_q, addr_q[1:0]);
      end
      WR: begin
        state_nxt      = RESP;
        resp_valid_nxt = 1'b1;
        rdata_nxt      = '0;
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, read-data capture and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      write_q       <= 1'b0;
      size_q        <= '0;
      unsigned_q    <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_word_q     <= '0;
      mem_readEn    <= 1'b0;
      mem_writeEn   <= 1'b0;
      mem_address   <= '0;
      mem_WriteData <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      misalign_err  <= 1'b0;
      range_err     <= 1'b0;
    end else begin
      if (accept) begin
        write_q    <= req_write;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata[15:0];
      end
      if (state == RD) rd_word_q <= mem_ReadData;
      mem_readEn    <= rd_en_nxt;
      mem_writeEn   <= wr_en_nxt;
      mem_address   <= addr_nxt;
      mem_WriteData <= wdata_nxt;
      resp_valid    <= resp_valid_nxt;
      resp_rdata    <= rdata_nxt;
      misalign_err  <= mis_nxt;
      range_err     <= rng_nxt;
    end
  end

endmodule
